// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D cache arbiter.
// Imported by the arbiter interface, the arbiter RTL and its testbench.
package cache_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and cacheline-adaptor signals around the arbiter.
// 'slave' is the arbiter's view; 'master' is the view of the caches and adaptor.
interface cache_arbiter_if
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LINE_W = DEFAULT_LINE_W
);

    logic [ADDR_W-1:0] i_address_i;
    logic              i_read_i;
    logic              i_write_i;
    logic [LINE_W-1:0] i_line_i;
    logic [LINE_W-1:0] i_line_o;
    logic              i_resp_o;

    logic [ADDR_W-1:0] d_address_i;
    logic              d_read_i;
    logic              d_write_i;
    logic [LINE_W-1:0] d_line_i;
    logic [LINE_W-1:0] d_line_o;
    logic              d_resp_o;

    logic [ADDR_W-1:0] mem_address_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [LINE_W-1:0] mem_line_o;
    logic [LINE_W-1:0] mem_line_i;
    logic              mem_resp_i;

    modport slave (
        input  i_address_i, i_read_i, i_write_i, i_line_i,
        output i_line_o, i_resp_o,
        input  d_address_i, d_read_i, d_write_i, d_line_i,
        output d_line_o, d_resp_o,
        output mem_address_o, mem_read_o, mem_write_o, mem_line_o,
        input  mem_line_i, mem_resp_i
    );

    modport master (
        output i_address_i, i_read_i, i_write_i, i_line_i,
        input  i_line_o, i_resp_o,
        output d_address_i, d_read_i, d_write_i, d_line_i,
        input  d_line_o, d_resp_o,
        input  mem_address_o, mem_read_o, mem_write_o, mem_line_o,
        output mem_line_i, mem_resp_i
    );

endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cacheline adaptor between the I-cache and D-cache.
// One transaction at a time: grant in IDLE, hold the request until the adaptor answers, pulse resp.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LINE_W = DEFAULT_LINE_W
) (
    input  logic            clk,
    input  logic            reset_n,
    cache_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    port_e             last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              is_write_q, is_write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] line_buf_q, line_buf_d;

    logic  i_req;
    logic  d_req;
    logic  serving;
    port_e gnt;

    assign i_req   = bus.i_read_i | bus.i_write_i;
    assign d_req   = bus.d_read_i | bus.d_write_i;
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        is_write_d   = is_write_q;
        wdata_d      = wdata_q;
        line_buf_d   = line_buf_q;
        gnt          = last_grant_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the port that lost last time wins.
                    if (i_req && d_req) begin
                        gnt = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
                    end else begin
                        gnt = d_req ? PORT_D : PORT_I;
                    end
                    last_grant_d = gnt;
                    // Read has priority when a port raises read and write together.
                    if (gnt == PORT_D) begin
                        addr_d     = bus.d_address_i;
                        is_write_d = !bus.d_read_i;
                        wdata_d    = bus.d_line_i;
                        state_d    = SERVE_D;
                    end else begin
                        addr_d     = bus.i_address_i;
                        is_write_d = !bus.i_read_i;
                        wdata_d    = bus.i_line_i;
                        state_d    = SERVE_I;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.mem_resp_i) begin
                    if (!is_write_q) begin
                        line_buf_d = bus.mem_line_i;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_I;
            addr_q       <= '0;
            is_write_q   <= 1'b0;
            // NOTE: the line registers are ordinary flops, so clearing them in reset is cheap and keeps the outputs defined.
            wdata_q      <= '0;
            line_buf_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            is_write_q   <= is_write_d;
            wdata_q      <= wdata_d;
            line_buf_q   <= line_buf_d;
        end
    end

    // Outputs are gated by reset_n so they read zero while reset is held, before the first edge.
    assign bus.mem_read_o    = reset_n && serving && !is_write_q;
    assign bus.mem_write_o   = reset_n && serving &&  is_write_q;
    assign bus.mem_address_o = reset_n ? addr_q  : '0;
    assign bus.mem_line_o    = reset_n ? wdata_q : '0;

    assign bus.i_resp_o = reset_n && (state_q == RESP) && (last_grant_q == PORT_I);
    assign bus.d_resp_o = reset_n && (state_q == RESP) && (last_grant_q == PORT_D);
    assign bus.i_line_o = reset_n ? line_buf_q : '0;
    assign bus.d_line_o = reset_n ? line_buf_q : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: requesters and a memory model drive directed vectors,
// a monitor compares every adaptor request and every resp against queued expectations.
module tb_cache_arbiter;
    import cache_arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    typedef struct {
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] line;
        logic          scramble;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [LW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        int            delay;
        logic [LW-1:0] line;
    } mem_rsp_t;

    typedef struct {
        port_e         port;
        logic [AW-1:0] addr;
        logic [LW-1:0] line;
    } resp_exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    req_t      i_q[$];
    req_t      d_q[$];
    mem_exp_t  mem_exp_q[$];
    mem_rsp_t  mem_rsp_q[$];
    resp_exp_t resp_exp_q[$];

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   i_req_cyc, d_req_cyc, op_start_cyc, op_len, resp_cyc;
    int   spur_req = 0;
    int   spur_done = 0;
    logic mem_resp_prev = 1'b0;

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        mem_resp_prev <= bus.mem_resp_i;
    end

    function automatic logic [LW-1:0] fill(input logic [31:0] w);
        return {8{w}};
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_mem_read"},  bus.mem_read_o, 0);
        check({name, "_mem_write"}, bus.mem_write_o, 0);
        check({name, "_mem_addr"},  bus.mem_address_o, 0);
        check({name, "_mem_line"},  bus.mem_line_o, 0);
        check({name, "_i_resp"},    bus.i_resp_o, 0);
        check({name, "_d_resp"},    bus.d_resp_o, 0);
        check({name, "_i_line"},    bus.i_line_o, 0);
        check({name, "_d_line"},    bus.d_line_o, 0);
    endtask

    function automatic req_t mk_req(input logic [AW-1:0] a, input logic rd, input logic wr,
                                    input logic [LW-1:0] l, input logic scr);
        req_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.line = l; r.scramble = scr;
        return r;
    endfunction

    task automatic push_mem(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
        mem_exp_t e;
        e.addr = a; e.write = w; e.wdata = wd;
        mem_exp_q.push_back(e);
    endtask

    task automatic push_rsp(input int delay, input logic [LW-1:0] l);
        mem_rsp_t e;
        e.delay = delay; e.line = l;
        mem_rsp_q.push_back(e);
    endtask

    task automatic push_resp(input port_e p, input logic [AW-1:0] a, input logic [LW-1:0] l);
        resp_exp_t e;
        e.port = p; e.addr = a; e.line = l;
        resp_exp_q.push_back(e);
    endtask

    // I-cache requester: holds each request until i_resp_o or reset.
    initial begin : i_requester
        req_t r;
        int   n;
        logic done;
        bus.i_address_i = '0; bus.i_read_i = 1'b0; bus.i_write_i = 1'b0; bus.i_line_i = '0;
        forever begin
            @(negedge clk);
            if (i_q.size() != 0 && reset_n) begin
                r = i_q.pop_front();
                bus.i_address_i = r.addr; bus.i_read_i = r.rd; bus.i_write_i = r.wr; bus.i_line_i = r.line;
                i_req_cyc = cyc;
                n = 0; done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    n++;
                    if (n == 3 && r.scramble) bus.i_line_i = ~r.line;
                    if (bus.i_resp_o || !reset_n) done = 1'b1;
                    else if (n > 200) begin
                        check("i_req_timeout", bus.i_resp_o, 1);
                        done = 1'b1;
                    end
                end
                bus.i_read_i = 1'b0; bus.i_write_i = 1'b0;
            end
        end
    end

    // D-cache requester: same protocol as the I side.
    initial begin : d_requester
        req_t r;
        int   n;
        logic done;
        bus.d_address_i = '0; bus.d_read_i = 1'b0; bus.d_write_i = 1'b0; bus.d_line_i = '0;
        forever begin
            @(negedge clk);
            if (d_q.size() != 0 && reset_n) begin
                r = d_q.pop_front();
                bus.d_address_i = r.addr; bus.d_read_i = r.rd; bus.d_write_i = r.wr; bus.d_line_i = r.line;
                d_req_cyc = cyc;
                n = 0; done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    n++;
                    if (n == 3 && r.scramble) bus.d_line_i = ~r.line;
                    if (bus.d_resp_o || !reset_n) done = 1'b1;
                    else if (n > 200) begin
                        check("d_req_timeout", bus.d_resp_o, 1);
                        done = 1'b1;
                    end
                end
                bus.d_read_i = 1'b0; bus.d_write_i = 1'b0;
            end
        end
    end

    // Adaptor model: answers each request after its programmed delay, or pulses spuriously on demand.
    initial begin : responder
        mem_rsp_t r;
        logic     abort;
        bus.mem_resp_i = 1'b0; bus.mem_line_i = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                bus.mem_resp_i = 1'b1; bus.mem_line_i = fill(32'hFFFF_0000);
                @(negedge clk);
                bus.mem_resp_i = 1'b0; bus.mem_line_i = '0;
                spur_done++;
            end else if (reset_n && (bus.mem_read_o || bus.mem_write_o)) begin
                if (mem_rsp_q.size() != 0) r = mem_rsp_q.pop_front();
                else begin r.delay = 2; r.line = '0; end
                abort = 1'b0;
                for (int k = 1; k < r.delay; k++) begin
                    @(negedge clk);
                    if (!reset_n) begin abort = 1'b1; break; end
                end
                if (!abort) begin
                    bus.mem_resp_i = 1'b1; bus.mem_line_i = r.line;
                    @(negedge clk);
                    bus.mem_resp_i = 1'b0; bus.mem_line_i = '0;
                end
            end
        end
    end

    initial begin : monitor
        logic          op, op_prev, resp_prev, any_resp;
        logic [AW-1:0] op_addr;
        logic [LW-1:0] op_wdata;
        logic          op_wr;
        mem_exp_t      me;
        resp_exp_t     re;
        op_prev = 1'b0; resp_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                op_prev = 1'b0; resp_prev = 1'b0;
            end else begin
                op       = bus.mem_read_o | bus.mem_write_o;
                any_resp = bus.i_resp_o | bus.d_resp_o;
                check("mem_rd_wr_excl", bus.mem_read_o & bus.mem_write_o, 0);
                check("resp_excl", bus.i_resp_o & bus.d_resp_o, 0);
                if (op && !op_prev) begin
                    op_start_cyc = cyc; op_len = 1;
                    op_addr = bus.mem_address_o; op_wr = bus.mem_write_o; op_wdata = bus.mem_line_o;
                    if (mem_exp_q.size() == 0) check("unexpected_mem_op", op, 0);
                    else begin
                        me = mem_exp_q.pop_front();
                        check("mem_addr", op_addr, me.addr);
                        check("mem_write", op_wr, me.write);
                        if (me.write) check("mem_wdata", op_wdata, me.wdata);
                    end
                end else if (op) begin
                    op_len++;
                    check("mem_addr_stable", bus.mem_address_o, op_addr);
                    check("mem_op_stable", bus.mem_write_o, op_wr);
                    check("mem_line_stable", bus.mem_line_o, op_wdata);
                end
                if (any_resp) begin
                    resp_cyc = cyc;
                    check("resp_single_cycle", resp_prev, 0);
                    check("resp_latency", mem_resp_prev, 1);
                    check("resp_mem_idle", op, 0);
                    if (resp_exp_q.size() == 0) check("unexpected_resp", any_resp, 0);
                    else begin
                        re = resp_exp_q.pop_front();
                        check("resp_port", {bus.i_resp_o, bus.d_resp_o}, (re.port == PORT_D) ? 2'b01 : 2'b10);
                        check("resp_line", (re.port == PORT_D) ? bus.d_line_o : bus.i_line_o, re.line);
                        check("resp_addr_held", bus.mem_address_o, re.addr);
                    end
                end
                op_prev = op; resp_prev = any_resp;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero(name);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((i_q.size() + d_q.size() + resp_exp_q.size() + mem_exp_q.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, resp_exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int n;
        do_reset("reset");

        // D read alone: op for 5 cycles, resp one cycle later.
        sync();
        push_mem(32'h0000_1000, 1'b0, '0);
        push_rsp(5, fill(32'hA5A5_A5A5));
        push_resp(PORT_D, 32'h0000_1000, fill(32'hA5A5_A5A5));
        d_q.push_back(mk_req(32'h0000_1000, 1'b1, 1'b0, '0, 1'b0));
        wait_done("d_read");
        check("d_read_op_latency", op_start_cyc - d_req_cyc, 1);
        check("d_read_resp_latency", resp_cyc - d_req_cyc, 6);
        check("d_read_op_len", op_len, 5);

        // Simultaneous reads right after reset: D first, then I.
        do_reset("reset2");
        sync();
        push_mem(32'h0000_0200, 1'b0, '0); push_rsp(3, fill(32'h2222_2222));
        push_mem(32'h0000_0100, 1'b0, '0); push_rsp(2, fill(32'h1111_1111));
        push_resp(PORT_D, 32'h0000_0200, fill(32'h2222_2222));
        push_resp(PORT_I, 32'h0000_0100, fill(32'h1111_1111));
        i_q.push_back(mk_req(32'h0000_0100, 1'b1, 1'b0, '0, 1'b0));
        d_q.push_back(mk_req(32'h0000_0200, 1'b1, 1'b0, '0, 1'b0));
        wait_done("tie_after_reset");

        // Continuous requests: D,I,D,I; I's read+write is served as a read, writes keep the buffer.
        sync();
        push_mem(32'h0000_0300, 1'b0, '0);                  push_rsp(2, fill(32'h3333_3333));
        push_mem(32'h0000_0400, 1'b0, '0);                  push_rsp(4, fill(32'h4444_4444));
        push_mem(32'h0000_0340, 1'b1, fill(32'hDEAD_BEEF)); push_rsp(2, fill(32'h0BAD_0BAD));
        push_mem(32'h0000_0440, 1'b1, fill(32'hCAFE_F00D)); push_rsp(3, fill(32'h0BAD_1BAD));
        push_resp(PORT_D, 32'h0000_0300, fill(32'h3333_3333));
        push_resp(PORT_I, 32'h0000_0400, fill(32'h4444_4444));
        push_resp(PORT_D, 32'h0000_0340, fill(32'h4444_4444));
        push_resp(PORT_I, 32'h0000_0440, fill(32'h4444_4444));
        d_q.push_back(mk_req(32'h0000_0300, 1'b1, 1'b0, '0, 1'b0));
        d_q.push_back(mk_req(32'h0000_0340, 1'b0, 1'b1, fill(32'hDEAD_BEEF), 1'b0));
        i_q.push_back(mk_req(32'h0000_0400, 1'b1, 1'b1, fill(32'h5555_5555), 1'b0));
        i_q.push_back(mk_req(32'h0000_0440, 1'b0, 1'b1, fill(32'hCAFE_F00D), 1'b0));
        wait_done("round_robin");

        // D write with d_line_i changed mid-transaction.
        sync();
        push_mem(32'h0000_2040, 1'b1, fill(32'h1234_5678)); push_rsp(4, fill(32'h0BAD_2BAD));
        push_resp(PORT_D, 32'h0000_2040, fill(32'h4444_4444));
        d_q.push_back(mk_req(32'h0000_2040, 1'b0, 1'b1, fill(32'h1234_5678), 1'b1));
        wait_done("d_write");

        // Reset during SERVE_I abandons the read; the next tie still goes to D.
        sync();
        push_mem(32'h0000_3000, 1'b0, '0); push_rsp(30, fill(32'h0BAD_3BAD));
        i_q.push_back(mk_req(32'h0000_3000, 1'b1, 1'b0, '0, 1'b0));
        n = 0;
        while (!bus.mem_read_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_op_started", bus.mem_read_o, 1);
        repeat (2) @(negedge clk);
        do_reset("reset_mid");
        repeat (3) @(negedge clk);
        sync();
        check_zero("post_reset_idle");
        push_mem(32'h0000_0600, 1'b0, '0); push_rsp(2, fill(32'h7777_7777));
        push_mem(32'h0000_0500, 1'b0, '0); push_rsp(2, fill(32'h6666_6666));
        push_resp(PORT_D, 32'h0000_0600, fill(32'h7777_7777));
        push_resp(PORT_I, 32'h0000_0500, fill(32'h6666_6666));
        i_q.push_back(mk_req(32'h0000_0500, 1'b1, 1'b0, '0, 1'b0));
        d_q.push_back(mk_req(32'h0000_0600, 1'b1, 1'b0, '0, 1'b0));
        wait_done("tie_after_abort");

        // Spurious adaptor response in IDLE is ignored; a following minimum-latency read still works.
        sync();
        spur_req++;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("spurious_quiet", {bus.i_resp_o, bus.d_resp_o, bus.mem_read_o, bus.mem_write_o}, 0);
        end
        sync();
        push_mem(32'h0000_0700, 1'b0, '0); push_rsp(1, fill(32'h8888_8888));
        push_resp(PORT_D, 32'h0000_0700, fill(32'h8888_8888));
        d_q.push_back(mk_req(32'h0000_0700, 1'b1, 1'b0, '0, 1'b0));
        wait_done("after_spurious");
        check("min_resp_latency", resp_cyc - d_req_cyc, 2);
        check("min_op_len", op_len, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter LINE_W, default 256, cacheline width of all ports.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 i_address_i  in  ADDR_W  I-cache line address.
REQ-006 i_read_i / i_write_i  in  1 each  I-cache read / write request.
REQ-007 i_line_i  in  LINE_W  I-cache writeback data; i_line_o  out  LINE_W  fill data; i_resp_o  out  1  I-cache done.
REQ-008 d_address_i, d_read_i, d_write_i, d_line_i, d_line_o, d_resp_o: D-cache port, same widths and meanings as I-cache port.
REQ-009 mem_address_o  out  ADDR_W;  mem_read_o / mem_write_o  out  1 each;  mem_line_o  out  LINE_W: request to the cacheline adaptor.
REQ-010 mem_line_i  in  LINE_W  adaptor fill data;  mem_resp_i  in  1  adaptor done (one-cycle pulse).

Function
REQ-011 FSM states: IDLE, SERVE_I, SERVE_D, RESP.
REQ-012 IDLE: if exactly one port requests (read|write), grant it; if both request, grant the port not granted last (round-robin); no request -> stay IDLE.
REQ-013 On grant (IDLE edge): latch granted port's address, op, and line_i into internal registers; set last_grant; enter SERVE_I/SERVE_D.
REQ-014 Read and write asserted together on one port: treated as read.
REQ-015 SERVE_x: mem_read_o/mem_write_o = latched op, mem_address_o/mem_line_o = latched values; all stable until mem_resp_i.
REQ-016 SERVE_x with mem_resp_i=1: capture mem_line_i into line buffer (reads only; writes keep buffer), enter RESP.
REQ-017 RESP: assert resp_o of the granted port only, exactly one cycle; mem_read_o=mem_write_o=0; next state IDLE unconditionally.
REQ-018 i_line_o and d_line_o both driven from the line buffer; valid only while matching resp_o=1.
REQ-019 Latency: request seen in IDLE at cycle N -> mem op asserted cycle N+1; mem_resp_i at cycle M -> resp_o at cycle M+1; minimum one IDLE cycle between transactions.
REQ-020 Requesters hold request until their resp_o; deassertion mid-transaction is ignored, transaction completes.
REQ-021 Request changes on the non-granted port during SERVE_x/RESP do not affect the current transaction; evaluated at next IDLE.
REQ-022 Never assert mem_read_o and mem_write_o together; never assert both resp_o together.
REQ-023 mem_resp_i in IDLE or RESP is ignored.

Reset
REQ-024 reset_n=0 at a rising edge: state IDLE, last_grant=I (D wins next tie), buffers cleared to 0.
REQ-025 During and after reset all outputs 0 (resp_o, mem_read_o, mem_write_o, lines, mem_address_o).
REQ-026 Reset mid-transaction abandons it; no resp_o issued for it.

Structure
REQ-027 Package cache_arb_pkg holds state enum, ADDR_W/LINE_W defaults, and port-select typedef (PORT_I, PORT_D).
REQ-028 Single module; no sub-module; round-robin logic inline.

Verification
REQ-029 D read only, addr 0x0000_1000, memory resp after 5 cycles with line 0xA5..A5 -> mem_read_o cycle 1 to 5, d_resp_o one cycle at 6, d_line_o=0xA5..A5, i_resp_o=0.
REQ-030 I and D read simultaneously after reset -> D served first, then I; mem_address_o switches only after d_resp_o.
REQ-031 Both ports request continuously for 4 transactions -> grants alternate D,I,D,I.
REQ-032 D write addr 0x0000_2040, d_line_i=0x1234.. -> mem_write_o=1, mem_line_o=0x1234..; changing d_line_i mid-transaction does not change mem_line_o.
REQ-033 reset_n low during SERVE_I -> next cycle all outputs 0, state IDLE, subsequent tie grants D.
REQ-034 Spurious mem_resp_i in IDLE -> no resp_o, no state change.
